// File: rtl/vga_scan_if.sv
// Display-side bundle of vga_scan: VRAM read port, lcdon enable and the sync/colour outputs.
interface vga_scan_if #(
   parameter int LINE_W = 6,
   parameter int COL_W  = 8,
   parameter int WORD_W = 4
);
   logic                     lcdon;
   logic [LINE_W+COL_W-1:0]  vram_a;
   logic [WORD_W-1:0]        vram_do;
   logic                     hsync;
   logic                     vsync;
   logic [11:0]              rgb;
   logic                     frame_sof;

   modport master (
      input  lcdon, vram_do,
      output vram_a, hsync, vsync, rgb, frame_sof
   );

   modport slave (
      output lcdon, vram_do,
      input  vram_a, hsync, vsync, rgb, frame_sof
   );
endinterface

// File: rtl/vga_scan.sv
// VGA scan-out engine: sync timing, windowed monochrome VRAM fetch, 2-clock colour pipeline.
// Build macro VGA_SCANLINE_EN: halves PIX_OFF_RGB on odd window lines (CRT scanline look).
module vga_scan #(
   parameter int          H_SYNC      = 96,
   parameter int          H_BP        = 40,
   parameter int          H_BORDER    = 8,
   parameter int          H_ACTIVE    = 640,
   parameter int          H_FP        = 8,
   parameter int          V_SYNC      = 2,
   parameter int          V_BP        = 25,
   parameter int          V_BORDER    = 8,
   parameter int          V_ACTIVE    = 480,
   parameter int          V_FP        = 2,
   parameter int          X_OFF       = 0,
   parameter int          Y_OFF       = 221,
   parameter int          SRC_W       = 640,
   parameter int          SRC_H       = 64,
   parameter int          V_SCALE     = 1,
   parameter int          WORD_W      = 4,
   parameter int          LINE_W      = 6,
   parameter int          COL_W       = 8,
   parameter int          SWAP_PAIRS  = 1,
   parameter logic [11:0] PIX_ON_RGB  = 12'h000,
   parameter logic [11:0] PIX_OFF_RGB = 12'hFFF,
   parameter logic [11:0] BORDER_RGB  = 12'h000
) (
   input  logic       vclk,
   input  logic       reset_n,
   vga_scan_if.master bus
);

   localparam int H_TOTAL = H_SYNC + H_BP + 2*H_BORDER + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + 2*V_BORDER + V_ACTIVE + V_FP;
   localparam int HC_W    = $clog2(H_TOTAL);
   localparam int VC_W    = $clog2(V_TOTAL);
   localparam int DX      = H_SYNC + H_BP + H_BORDER + X_OFF;
   localparam int DY      = V_SYNC + V_BP + V_BORDER + Y_OFF;
   localparam int PH_SH   = $clog2(WORD_W);
   localparam int PH_W    = (WORD_W > 1) ? PH_SH : 1;
   localparam int REP_W   = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;

   localparam logic [HC_W-1:0]  H_LAST  = HC_W'(H_TOTAL - 1);
   localparam logic [VC_W-1:0]  V_LAST  = VC_W'(V_TOTAL - 1);
   localparam logic [HC_W-1:0]  H_SYNC_C = HC_W'(H_SYNC);
   localparam logic [VC_W-1:0]  V_SYNC_C = VC_W'(V_SYNC);
   localparam logic [HC_W-1:0]  DX_C    = HC_W'(DX);
   localparam logic [VC_W-1:0]  DY_C    = VC_W'(DY);
   localparam logic [HC_W:0]    WX_LO   = (HC_W+1)'(DX);
   localparam logic [HC_W:0]    WX_HI   = (HC_W+1)'(DX + SRC_W);
   localparam logic [VC_W:0]    WY_LO   = (VC_W+1)'(DY);
   localparam logic [VC_W:0]    WY_HI   = (VC_W+1)'(DY + SRC_H*V_SCALE);
   localparam logic [HC_W:0]    AX_LO   = (HC_W+1)'(H_SYNC + H_BP);
   localparam logic [HC_W:0]    AX_HI   = (HC_W+1)'(H_SYNC + H_BP + 2*H_BORDER + H_ACTIVE - 1);
   localparam logic [VC_W:0]    AY_LO   = (VC_W+1)'(V_SYNC + V_BP);
   localparam logic [VC_W:0]    AY_HI   = (VC_W+1)'(V_SYNC + V_BP + 2*V_BORDER + V_ACTIVE - 1);
   localparam logic [REP_W-1:0] REP_MAX = REP_W'(V_SCALE - 1);

   function automatic logic [PH_W-1:0] bit_index(input logic [PH_W-1:0] p);
      return (SWAP_PAIRS != 0) ? (p ^ PH_W'(1)) : (PH_W'(WORD_W - 1) - p);
   endfunction

`ifdef VGA_SCANLINE_EN
   function automatic logic [11:0] dim_rgb(input logic [11:0] c);
      return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
   endfunction
`endif

   logic [HC_W-1:0]   hcount;
   logic [VC_W-1:0]   vcount;
   logic [VC_W-1:0]   vcount_nx;
   logic [REP_W-1:0]  rep;
   logic [LINE_W-1:0] line_idx;
   logic              en_q;
   logic              h_last, v_last, h_win, v_win;
   logic [HC_W-1:0]   hoff;
   logic [HC_W-1:0]   word_p0;
   logic [PH_W-1:0]   phase_p0;
   logic              in_win_p0, active_p0, raw_hs_p0, raw_vs_p0, sof_p0;

   // ---- stage 0: counters, window decode, VRAM address ----
   always_comb begin
      h_last    = (hcount == H_LAST);
      v_last    = (vcount == V_LAST);
      vcount_nx = v_last ? '0 : vcount + 1'b1;
      h_win     = ({1'b0, hcount} >= WX_LO) && ({1'b0, hcount} < WX_HI);
      v_win     = ({1'b0, vcount} >= WY_LO) && ({1'b0, vcount} < WY_HI);
      in_win_p0 = h_win && v_win;
      active_p0 = ({1'b0, hcount} >= AX_LO) && ({1'b0, hcount} <= AX_HI) &&
                  ({1'b0, vcount} >= AY_LO) && ({1'b0, vcount} <= AY_HI);
      raw_hs_p0 = (hcount < H_SYNC_C);
      raw_vs_p0 = (vcount < V_SYNC_C);
      sof_p0    = (hcount == '0) && (vcount == '0);
      hoff      = hcount - DX_C;
      phase_p0  = hoff[PH_W-1:0];
      word_p0   = hoff >> PH_SH;
      bus.vram_a = in_win_p0 ? {line_idx, COL_W'(word_p0)} : '1;
   end

`ifdef VGA_SCANLINE_EN
   logic [VC_W-1:0] voff;
   logic            odd_p0, odd_p1;
   always_comb begin
      voff   = vcount - DY_C;
      odd_p0 = voff[0];
   end
`endif

   // Source line stepping: rep counts repeats of one source line, so no divider is needed.
   always_ff @(posedge vclk) begin
      if (!reset_n) begin
         hcount   <= '0;
         vcount   <= '0;
         rep      <= '0;
         line_idx <= '0;
         en_q     <= 1'b0;
      end else if (h_last) begin
         hcount <= '0;
         vcount <= vcount_nx;
         if (vcount_nx == DY_C) begin
            rep      <= '0;
            line_idx <= '0;
         end else if (v_win) begin
            if (rep == REP_MAX) begin
               rep      <= '0;
               line_idx <= line_idx + 1'b1;
            end else begin
               rep <= rep + 1'b1;
            end
         end
         if (v_last)
            en_q <= bus.lcdon;
      end else begin
         hcount <= hcount + 1'b1;
      end
   end

   // ---- stage 1: VRAM data arrives, pick the pixel bit ----
   logic            vld_p1;
   logic            in_win_p1, active_p1, raw_hs_p1, raw_vs_p1, sof_p1, en_p1;
   logic [PH_W-1:0] phase_p1;
   logic            pix_p1;
   logic [11:0]     rgb_p1;

   always_ff @(posedge vclk) begin
      if (!reset_n)
         vld_p1 <= 1'b0;
      else
         vld_p1 <= 1'b1;
   end

   always_ff @(posedge vclk) begin
      in_win_p1 <= in_win_p0;
      active_p1 <= active_p0;
      raw_hs_p1 <= raw_hs_p0;
      raw_vs_p1 <= raw_vs_p0;
      sof_p1    <= sof_p0;
      en_p1     <= en_q;
      phase_p1  <= phase_p0;
`ifdef VGA_SCANLINE_EN
      odd_p1    <= odd_p0;
`endif
   end

   always_comb begin
      pix_p1 = bus.vram_do[bit_index(phase_p1)];
      rgb_p1 = PIX_OFF_RGB;
      if (!active_p1)
         rgb_p1 = '0;
      else if (!in_win_p1 || !en_p1)
         rgb_p1 = BORDER_RGB;
      else if (pix_p1)
         rgb_p1 = PIX_ON_RGB;
`ifdef VGA_SCANLINE_EN
      else if (odd_p1)
         rgb_p1 = dim_rgb(PIX_OFF_RGB);
`endif
      else
         rgb_p1 = PIX_OFF_RGB;
   end

   // ---- stage 2: registered outputs ----
   logic        hsync_p2, vsync_p2, sof_p2;
   logic [11:0] rgb_p2;

   always_ff @(posedge vclk) begin
      if (!reset_n || !vld_p1) begin
         hsync_p2 <= 1'b1;
         vsync_p2 <= 1'b1;
         rgb_p2   <= '0;
         sof_p2   <= 1'b0;
      end else begin
         hsync_p2 <= ~raw_hs_p1;
         vsync_p2 <= ~raw_vs_p1;
         rgb_p2   <= rgb_p1;
         sof_p2   <= sof_p1;
      end
   end

   assign bus.hsync     = hsync_p2;
   assign bus.vsync     = vsync_p2;
   assign bus.rgb       = rgb_p2;
   assign bus.frame_sof = sof_p2;

endmodule
